// File: rtl/two_digit_bcd_display.sv
// Two-digit BCD display: counts decade carries into a tens digit and
// time-multiplexes the units/tens digits onto an active-low 7-segment display.
// Ports: clk, reset (sync, active-high), carry_in, units[3:0] in;
//        tens[3:0], overflow, seg[6:0] {g..a} active-low, an[3:0] active-low out.
// Optional: define BCD_BLANK_LEADING_ZERO_EN to blank the tens digit when it is 0.
module two_digit_bcd_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       carry_in,
  input  logic [3:0] units,
  output logic [3:0] tens,
  output logic       overflow,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic {
    SHOW_UNITS = 1'b0,
    SHOW_TENS  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          carry_prev;
  logic          carry_edge;
  logic [CW-1:0] refresh_cnt;
  logic          tick;
  logic [3:0]    digit;
  logic [6:0]    seg_nxt;
  logic [3:0]    an_nxt;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;  // non-BCD input shows a dash
    endcase
    return s;
  endfunction

  // carry_prev clears on reset, so a carry already high at reset release
  // is seen as a fresh edge on the first running cycle.
  assign carry_edge = carry_in & ~carry_prev;
  assign tick       = (refresh_cnt == REFRESH_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      carry_prev  <= 1'b0;
      tens        <= 4'd0;
      overflow    <= 1'b0;
      refresh_cnt <= '0;
    end else begin
      carry_prev <= carry_in;
      overflow   <= 1'b0;
      if (carry_edge) begin
        if (tens == 4'd9) begin
          tens     <= 4'd0;
          overflow <= 1'b1;
        end else begin
          tens <= tens + 4'd1;
        end
      end
      refresh_cnt <= tick ? '0 : refresh_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SHOW_UNITS;
      seg   <= 7'b1111111;
      an    <= 4'b1111;
    end else begin
      state <= state_nxt;
      seg   <= seg_nxt;
      an    <= an_nxt;
    end
  end

  // Display outputs are decoded from the state being left, so the digit
  // enables trail the FSM by one cycle together with the segments.
  always_comb begin
    state_nxt = state;
    digit     = units;
    an_nxt    = 4'b1110;
    if (tick) begin
      state_nxt = (state == SHOW_UNITS) ? SHOW_TENS : SHOW_UNITS;
    end
    if (state == SHOW_TENS) begin
      digit  = tens;
      an_nxt = 4'b1101;
    end
    seg_nxt = bcd_to_seg(digit);
`ifdef BCD_BLANK_LEADING_ZERO_EN
    if (state == SHOW_TENS && tens == 4'd0) begin
      seg_nxt = 7'b1111111;
      an_nxt  = 4'b1111;
    end
`endif
  end

endmodule
